armleocpu_axi_ram: RTL
======================

# armleocpu_axi_ram

AXI4 single-port word RAM slave for the cache's memory-side port, with an exclusive-access monitor and out-of-range error signalling. It sits directly downstream of the cache AXI master in cache and CPU benches. It serves single-beat writes, single-beat INCR reads and 8-beat WRAP line refills, with one outstanding transaction at a time.

## Interface
- DEPTH_LOG2, 10: memory size is 2^DEPTH_LOG2 32-bit words.
- ADDR_WIDTH, 34: AXI address width.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- axi_awvalid/axi_awready  in/out  1  write address handshake.
- axi_awaddr  input  ADDR_WIDTH  write byte address.
- axi_awlock  input  1  exclusive write.
- axi_wvalid/axi_wready  in/out  1  write data handshake.
- axi_wdata  input  32  write data.
- axi_wstrb  input  4  byte enables.
- axi_wlast  input  1  must be 1.
- axi_bvalid/axi_bready  out/in  1  write response handshake.
- axi_bresp  output  2  OKAY=00, EXOKAY=01, SLVERR=10.
- axi_arvalid/axi_arready  in/out  1  read address handshake.
- axi_araddr  input  ADDR_WIDTH  read byte address.
- axi_arlen  input  8  beats minus one.
- axi_arburst  input  2  INCR=01, WRAP=10.
- axi_arlock  input  1  exclusive read.
- axi_rvalid/axi_rready  out/in  1  read data handshake.
- axi_rdata  output  32  read data.
- axi_rresp  output  2  read response.
- axi_rlast  output  1  last beat.

## Operation
- FSM states: IDLE, WDATA, BRESP, RDATA.
- Word index = addr[DEPTH_LOG2+1:2]. An address is out of range if any bit of addr[ADDR_WIDTH-1:DEPTH_LOG2+2] is 1.
- IDLE:
  - axi_awready=1 and axi_arready=!axi_awvalid, so writes win when both requests arrive together.
  - AW handshake latches addr/lock and moves to WDATA.
  - AR handshake latches addr/len/burst/lock and moves to RDATA.
- WDATA:
  - axi_wready=1.
  - On the W handshake: if in range and wlast=1 (and the exclusive check passes), each byte k with wstrb[k]=1 is written. Otherwise memory is unchanged.
  - Response: SLVERR if out of range or wlast=0; else EXOKAY/OKAY per the monitor.
  - Next state BRESP.
- BRESP:
  - axi_bvalid=1 and axi_bresp held stable until axi_bready, then IDLE.
- RDATA:
  - axi_rvalid=1 and axi_rdata = mem[current word].
  - Legal combos: INCR with len=0; WRAP with len=7.
  - WRAP next address keeps addr[ADDR_WIDTH-1:5], increments addr[4:2] modulo 8, byte offset 00.
  - Illegal combo or out of range: every beat returns SLVERR with rdata=0, and len+1 beats are still issued.
  - A beat counter counts down from len. axi_rlast=1 when it is 0.
  - On a handshake with rlast=1, go to IDLE.
- Reset: FSM to IDLE, reservation cleared, counters cleared. Memory contents are not reset.

## Timing
- While rst_n=0: all valid/ready outputs 0; bresp, rresp, rdata, rlast 0.
- AW/AR accepted in the same cycle as valid while in IDLE (ready is combinational from state).
- rvalid is asserted the cycle after the AR handshake; each subsequent beat appears the cycle after the previous handshake. With rready held high: 1 beat per cycle, 8-beat refill = 9 cycles from AR.
- bvalid is asserted the cycle after the W handshake.
- rdata/rresp/rlast are stable while rvalid=1 and rready=0.
- Reset mid-burst: the burst is abandoned and no further beats are issued.
- An exclusive write is judged against the reservation state at the W handshake cycle.

## Configuration
- ARMLEOCPU_AXI_EXCLUSIVE_EN defined:
  - Single reservation {valid, word index}.
  - Legal in-range AR with arlock: sets the reservation and rresp=EXOKAY for all beats.
  - Write with awlock: succeeds only if the reservation is valid and matches the word index; then the write is performed, bresp=EXOKAY and the reservation is cleared. Otherwise no write and bresp=OKAY.
  - Any successful normal write to the reserved word clears the reservation.
- Not defined: arlock and awlock are ignored, no reservation state exists, and exclusive accesses behave as normal accesses with OKAY.

## Test plan
- Write 0xDEADBEEF, wstrb=1111, to 0x40, then INCR len0 read 0x40 -> rdata 0xDEADBEEF, rresp 00, rlast 1. Then write 0x000000AA with wstrb=0001 -> read gives 0xDEADBEAA.
- Words 0x00..0x1C preloaded with their addresses, WRAP len7 read at 0x14 -> rdata order 0x14, 0x18, 0x1C, 0x00, 0x04, 0x08, 0x0C, 0x10; rlast only on the 8th beat; rready toggled every other cycle -> data held stable while stalled.
- Read at 1<<(DEPTH_LOG2+2) -> rresp 10, rdata 0. Write to the same address -> bresp 10, memory unchanged. INCR with len=3 -> 4 beats of SLVERR.
- (EXCLUSIVE_EN) Locked read 0x80, locked write 0x80 = 5 -> bresp 01 and mem = 5. Second locked write of 6 -> bresp 00 and mem stays 5.
- (EXCLUSIVE_EN) Locked read 0x80, normal write 0x80 = 7, locked write 0x80 = 9 -> bresp 00 and mem = 7.
- Assert rst_n=0 after the 3rd WRAP beat -> rvalid 0 next cycle, FSM in IDLE. A new read then returns correct data and the old burst does not resume.

Source files
------------

// File: rtl/armleocpu_axi_ram.sv
// AXI4 single-port 32-bit word RAM slave: single-beat writes, INCR/WRAP8 reads, SLVERR on out-of-range.
// Define ARMLEOCPU_AXI_EXCLUSIVE_EN to enable the single-entry exclusive-access monitor.
module armleocpu_axi_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_WIDTH = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                  axi_awlock,

  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [31:0]           axi_wdata,
  input  logic [3:0]            axi_wstrb,
  input  logic                  axi_wlast,

  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,

  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  input  logic [1:0]            axi_arburst,
  input  logic                  axi_arlock,

  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [31:0]           axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, BRESP, RDATA} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [7:0]             count_reg, count_next;
  logic                   rerr_reg, rerr_next;
  logic [1:0]             bresp_reg, bresp_next;

  logic [31:0]            mem [DEPTH];
  logic [31:0]            rdata_reg;

  logic [DEPTH_LOG2-1:0]  cur_idx, ar_idx, wrap_idx, rd_idx;
  logic [ADDR_WIDTH-1:0]  wrap_addr;
  logic                   cur_in_range, ar_in_range, ar_legal;
  logic                   w_hs, wr_ok, wr_allow, mem_we, mem_re;
  logic [1:0]             wr_resp;
  logic                   unused_bits;

  assign cur_idx      = addr_reg[DEPTH_LOG2+1:2];
  assign ar_idx       = axi_araddr[DEPTH_LOG2+1:2];
  assign cur_in_range = ~|addr_reg[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign ar_in_range  = ~|axi_araddr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign ar_legal     = ((axi_arburst == BURST_INCR) && (axi_arlen == 8'd0)) ||
                        ((axi_arburst == BURST_WRAP) && (axi_arlen == 8'd7));

  // WRAP8 stays inside the 32-byte line: only the word-in-line bits advance.
  assign wrap_addr = {addr_reg[ADDR_WIDTH-1:5], addr_reg[4:2] + 3'd1, 2'b00};
  assign wrap_idx  = wrap_addr[DEPTH_LOG2+1:2];

  assign w_hs  = (state_reg == WDATA) && axi_wvalid;
  assign wr_ok = cur_in_range && axi_wlast;

`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
  logic                  lock_reg, lock_next;
  logic                  rexcl_reg, rexcl_next;
  logic                  resv_valid_reg, resv_valid_next;
  logic [DEPTH_LOG2-1:0] resv_idx_reg, resv_idx_next;
  logic                  resv_hit;

  assign resv_hit = resv_valid_reg && (resv_idx_reg == cur_idx);
  assign wr_allow = wr_ok && (!lock_reg || resv_hit);
  assign wr_resp  = !wr_ok ? RESP_SLVERR : ((lock_reg && resv_hit) ? RESP_EXOKAY : RESP_OKAY);
  assign unused_bits = ^addr_reg[1:0];
`else
  assign wr_allow = wr_ok;
  assign wr_resp  = wr_ok ? RESP_OKAY : RESP_SLVERR;
  assign unused_bits = ^{addr_reg[1:0], axi_awlock, axi_arlock};
`endif

  assign mem_we = rst_n && w_hs && wr_allow;
  // Prefetch the next beat's word on each handshake so rdata is ready one cycle later.
  assign mem_re = rst_n && (((state_reg == IDLE) && !axi_awvalid && axi_arvalid) ||
                            ((state_reg == RDATA) && axi_rready && (count_reg != 8'd0)));
  assign rd_idx = (state_reg == RDATA) ? wrap_idx : ar_idx;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_wstrb[b]) mem[cur_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
      end
    end
    if (mem_re) rdata_reg <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      count_reg      <= 8'd0;
      rerr_reg       <= 1'b0;
      bresp_reg      <= RESP_OKAY;
`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
      lock_reg       <= 1'b0;
      rexcl_reg      <= 1'b0;
      resv_valid_reg <= 1'b0;
      resv_idx_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      count_reg      <= count_next;
      rerr_reg       <= rerr_next;
      bresp_reg      <= bresp_next;
`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
      lock_reg       <= lock_next;
      rexcl_reg      <= rexcl_next;
      resv_valid_reg <= resv_valid_next;
      resv_idx_reg   <= resv_idx_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    count_next  = count_reg;
    rerr_next   = rerr_reg;
    bresp_next  = bresp_reg;
`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
    lock_next       = lock_reg;
    rexcl_next      = rexcl_reg;
    resv_valid_next = resv_valid_reg;
    resv_idx_next   = resv_idx_reg;
`endif
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = RESP_OKAY;
    axi_rvalid  = 1'b0;
    axi_rdata   = 32'd0;
    axi_rresp   = RESP_OKAY;
    axi_rlast   = 1'b0;

    // Outputs stay quiet while reset is asserted, whatever state the register holds.
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          axi_awready = 1'b1;
          axi_arready = !axi_awvalid;
          if (axi_awvalid) begin
            addr_next  = axi_awaddr;
`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
            lock_next  = axi_awlock;
`endif
            state_next = WDATA;
          end else if (axi_arvalid) begin
            addr_next  = axi_araddr;
            count_next = axi_arlen;
            rerr_next  = !(ar_legal && ar_in_range);
`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
            rexcl_next = ar_legal && ar_in_range && axi_arlock;
            if (ar_legal && ar_in_range && axi_arlock) begin
              resv_valid_next = 1'b1;
              resv_idx_next   = ar_idx;
            end
`endif
            state_next = RDATA;
          end
        end
        WDATA: begin
          axi_wready = 1'b1;
          if (axi_wvalid) begin
            bresp_next = wr_resp;
`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
            if (mem_we && resv_hit) resv_valid_next = 1'b0;
`endif
            state_next = BRESP;
          end
        end
        BRESP: begin
          axi_bvalid = 1'b1;
          axi_bresp  = bresp_reg;
          if (axi_bready) state_next = IDLE;
        end
        RDATA: begin
          axi_rvalid = 1'b1;
          axi_rdata  = rerr_reg ? 32'd0 : rdata_reg;
`ifdef ARMLEOCPU_AXI_EXCLUSIVE_EN
          axi_rresp  = rerr_reg ? RESP_SLVERR : (rexcl_reg ? RESP_EXOKAY : RESP_OKAY);
`else
          axi_rresp  = rerr_reg ? RESP_SLVERR : RESP_OKAY;
`endif
          axi_rlast  = (count_reg == 8'd0);
          if (axi_rready) begin
            if (count_reg == 8'd0) begin
              state_next = IDLE;
            end else begin
              count_next = count_reg - 8'd1;
              addr_next  = wrap_addr;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
